mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store controller between the CPU MEM stage and the 4 KB data memory (dm_4k).
- Accepts one request at a time over a valid/ready handshake and checks alignment and range.
- Drives the data memory's word-address, byte-mode and byte-select ports. Splits halfword accesses into two byte accesses.
- Returns zero- or sign-extended load data, plus an error flag, on a one-cycle response strobe.

Parameters:
- DM_AW, 10, data-memory word-address width; addressable range is 4*2^DM_AW bytes.
- CHECK_RANGE, 1, when 1, any request with req_addr[31:DM_AW+2] != 0 is an error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; equals (state==IDLE).
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend; ignored for word and for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion strobe; fires for loads and stores.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size or out-of-range; valid with resp_valid.
- dm_addr  out  DM_AW  word address to memory.
- dm_din  out  32  write data to memory.
- dm_we  out  1  memory write enable.
- dm_bmode  out  1  1=byte access.
- dm_bsel  out  2  byte lane.
- dm_dout  in  32  memory read data; combinational; byte mode returns the lane sign-extended.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - dm_we=0, dm_bmode=0, dm_bsel=0, dm_addr=0, dm_din=0.
  - Latched request registers cleared.
  - req_ready=1 once in IDLE.
- Reset mid-operation:
  - Aborts immediately; no response is issued.
  - A half store interrupted after ACC0 leaves its low byte written. This is accepted.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - Handshake = req_valid & req_ready at a rising edge.
  - On handshake, latch we, size, unsigned, addr and wdata.
  - Compute err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (CHECK_RANGE & addr out of range).
  - err=1 -> RESP with resp_err=1, resp_rdata=0; no memory access (dm_we never asserted).
  - else -> ACC0.
- Memory port drive:
  - dm_addr = addr[DM_AW+1:2] for the whole transaction.
  - dm_we=1 only in ACC0/ACC1 when we=1; 0 in IDLE and RESP.
- ACC0:
  - Word: dm_bmode=0, dm_din=wdata.
  - Byte: dm_bmode=1, dm_bsel=addr[1:0], dm_din[7:0]=wdata[7:0].
  - Half: dm_bmode=1, dm_bsel={addr[1],0}, dm_din[7:0]=wdata[7:0] (little-endian low byte).
  - Loads capture dm_dout at the end of ACC0.
  - Half -> ACC1; others -> RESP.
- ACC1 (half only):
  - dm_bsel={addr[1],1}, dm_din[7:0]=wdata[15:8].
  - Loads capture dm_dout[7:0] as the high byte.
  - -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then -> IDLE.
  - req_ready=0 in RESP, so back-to-back requests see a one-cycle bubble.
- Load result formatting:
  - Word: dm_dout unchanged.
  - Byte: unsigned -> {24'b0, b[7:0]}; signed -> {{24{b[7]}}, b[7:0]}.
  - Half: h={hi,lo}; unsigned -> {16'b0, h}; signed -> {{16{h[15]}}, h}.
- Latency, counted from the handshake edge T:
  - Word/byte: ACC0 in cycle T+1, resp_valid in T+2.
  - Half: resp_valid in T+3.
  - Error: resp_valid in T+1.
- Request inputs are ignored outside IDLE; the latched copies are used.
- Stores always return resp_rdata=0.

Test Plan:
- Word store then load:
  - Store 0x0000_0010 <- 0xDEADBEEF, then load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
  - dm_we high exactly one cycle; resp_valid 2 cycles after each handshake.
- Byte loads after the above:
  - Load byte 0x13 signed -> 0xFFFFFFDE.
  - Load byte 0x13 unsigned -> 0x000000DE.
  - Load byte 0x10 signed -> 0xFFFFFFEF.
- Half access:
  - Store half 0x22 <- 0x0000_8001, then load half 0x22 signed -> 0xFFFF8001, unsigned -> 0x00008001.
  - dm_bsel sequence 2 then 3; response 3 cycles after the handshake.
  - Word at 0x20 now reads 0x8001_xxxx with the low half unchanged.
- Errors:
  - Word load at 0x11, half at 0x21, size=11, and addr 0x0000_1000 (CHECK_RANGE=1).
  - Each -> resp_err=1, resp_rdata=0, resp_valid at T+1, dm_we never asserted, memory contents unchanged.
- Back-to-back:
  - req_valid held high with 3 word loads -> req_ready low during ACC0/RESP.
  - Handshakes at cycles 0, 3, 6; three responses, in order.
- Async reset:
  - Drop rst_n during ACC1 of a half store -> dm_we and resp_valid go to 0 immediately, without waiting for a clock edge.
  - After release: req_ready=1, no response emitted, next word load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and the 4 KB data memory.
// One request at a time; halfwords are split into two byte accesses.
module mem_access_unit #(
    parameter int unsigned DM_AW       = 10,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_we,
    output logic             dm_bmode,
    output logic [1:0]       dm_bsel,
    input  logic [31:0]      dm_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_addr_lo;
    logic [31:0]       r_wdata;
    logic [7:0]        r_lo;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic [DM_AW-1:0]  r_dm_addr;
    logic [31:0]       r_dm_din;
    logic              r_dm_we;
    logic              r_dm_bmode;
    logic [1:0]        r_dm_bsel;

    logic [31:0]       w_hi_bits;
    logic              w_oor;
    logic              w_err;

    assign w_hi_bits = req_addr >> (DM_AW + 2);
    assign w_oor     = CHECK_RANGE && (w_hi_bits != '0);
    assign w_err     = (req_size == 2'b11)
                     | ((req_size == SZ_HALF) & req_addr[0])
                     | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                     | w_oor;

    // h carries {hi, lo} for halves, lane byte in h[7:0] for bytes
    function automatic logic [31:0] f_extend(input logic [1:0] size, input logic uns,
                                             input logic [15:0] h, input logic [31:0] word);
        logic [31:0] v;
        case (size)
            SZ_BYTE: v = uns ? {24'b0, h[7:0]} : {{24{h[7]}}, h[7:0]};
            SZ_HALF: v = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: v = word;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= '0;
            r_wdata      <= '0;
            r_lo         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_dm_addr    <= '0;
            r_dm_din     <= '0;
            r_dm_we      <= 1'b0;
            r_dm_bmode   <= 1'b0;
            r_dm_bsel    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr_lo  <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        r_dm_addr  <= req_addr[DM_AW+1:2];
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_dm_we      <= 1'b0;
                        end else begin
                            r_state    <= S_ACC0;
                            r_resp_err <= 1'b0;
                            r_dm_we    <= req_we;
                            r_dm_bmode <= (req_size != SZ_WORD);
                            r_dm_bsel  <= (req_size == SZ_HALF) ? {req_addr[1], 1'b0}
                                                                : req_addr[1:0];
                            r_dm_din   <= (req_size == SZ_WORD) ? req_wdata
                                                                : {24'b0, req_wdata[7:0]};
                        end
                    end
                end
                S_ACC0: begin
                    if (r_size == SZ_HALF) begin
                        r_state   <= S_ACC1;
                        r_lo      <= dm_dout[7:0];
                        r_dm_bsel <= {r_addr_lo[1], 1'b1};
                        r_dm_din  <= {24'b0, r_wdata[15:8]};
                    end else begin
                        r_state      <= S_RESP;
                        r_dm_we      <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_we ? '0
                                             : f_extend(r_size, r_unsigned, dm_dout[15:0], dm_dout);
                    end
                end
                S_ACC1: begin
                    r_state      <= S_RESP;
                    r_dm_we      <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_we ? '0
                                         : f_extend(SZ_HALF, r_unsigned, {dm_dout[7:0], r_lo}, dm_dout);
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign dm_addr    = r_dm_addr;
    assign dm_din     = r_dm_din;
    assign dm_we      = r_dm_we;
    assign dm_bmode   = r_dm_bmode;
    assign dm_bsel    = r_dm_bsel;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: dm_4k behavioural memory plus a byte-array
// reference model; directed plan cases followed by randomized requests.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic        dm_bmode;
    logic [1:0]  dm_bsel;
    logic [31:0] dm_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DM_AW(10), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
        .dm_bmode(dm_bmode), .dm_bsel(dm_bsel), .dm_dout(dm_dout)
    );

    // Data memory as seen by the unit: word array, byte lanes sign-extended on read
    logic [31:0] dm_mem [0:1023];
    logic [7:0]  ref_mem [0:4095];
    logic        mem_init = 1'b0;
    logic [31:0] w_word;
    logic [7:0]  w_lane;

    assign w_word  = dm_mem[dm_addr];
    assign w_lane  = w_word[8*dm_bsel +: 8];
    assign dm_dout = dm_bmode ? {{24{w_lane[7]}}, w_lane} : w_word;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++)
                dm_mem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        end else if (dm_we) begin
            if (dm_bmode) dm_mem[dm_addr][8*dm_bsel +: 8] <= dm_din[7:0];
            else          dm_mem[dm_addr] <= dm_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, results from plain arithmetic
    function automatic void ref_exec(input logic we, input logic [1:0] size, input logic uns,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic err,
                                     output int lat, output int nwe);
        int unsigned nbytes;
        logic [31:0] v;
        rd = '0;
        nwe = 0;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((a % nbytes) != 0) || (a >= 32'd4096);
        if (err) begin
            lat = 1;
            return;
        end
        lat = (nbytes == 2) ? 3 : 2;
        if (we) begin
            for (int unsigned i = 0; i < nbytes; i++) ref_mem[a + i] = wd[8*i +: 8];
            nwe = (nbytes == 2) ? 2 : 1;
        end else begin
            v = '0;
            for (int unsigned i = 0; i < nbytes; i++) v = v + (32'(ref_mem[a + i]) << (8*i));
            if (!uns && nbytes < 4 && v >= (32'd1 << (8*nbytes - 1)))
                v = v - (32'd1 << (8*nbytes));
            rd = v;
        end
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input string tag, output logic [31:0] got);
        logic [31:0] e_rd;
        logic        e_err, g_err, bm1;
        int          e_lat, e_nwe, lat, nwe, n;
        logic [1:0]  bsel1, bsel2;
        logic [9:0]  da1;
        ref_exec(we, size, uns, a, wd, e_rd, e_err, e_lat, e_nwe);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; nwe = 0; got = '0; g_err = 1'b0;
        bsel1 = '0; bsel2 = '0; bm1 = 1'b0; da1 = '0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (dm_we) nwe++;
            if (k == 1) begin bsel1 = dm_bsel; bm1 = dm_bmode; da1 = dm_addr; end
            if (k == 2) bsel2 = dm_bsel;
            if (resp_valid) begin lat = k; got = resp_rdata; g_err = resp_err; end
        end
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_err"}, 32'(g_err), 32'(e_err));
        check({tag, "_rdata"}, got, e_rd);
        check({tag, "_nwe"}, nwe, e_nwe);
        if (!e_err) begin
            check({tag, "_dmaddr"}, 32'(da1), 32'(a[11:2]));
            check({tag, "_bmode"}, 32'(bm1), 32'(size != 2'd2));
            if (size == 2'd1) begin
                check({tag, "_bsel0"}, 32'(bsel1), 32'({a[1], 1'b0}));
                check({tag, "_bsel1"}, 32'(bsel2), 32'({a[1], 1'b1}));
            end
            if (size == 2'd0) check({tag, "_bsel"}, 32'(bsel1), 32'(a[1:0]));
        end
        @(negedge clk);
        check({tag, "_strobe"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, a, wd;
        logic [1:0]  size;
        logic        e_err;
        int          e_lat, e_nwe, hs, rs, s, mism;
        int          hs_cyc [3];
        logic [31:0] bb_addr [3];
        logic [31:0] bb_exp [3];

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        mem_init = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_rerr", 32'(resp_err), 32'd0);
        check("rst_dmwe", 32'(dm_we), 32'd0);
        check("rst_bmode", 32'(dm_bmode), 32'd0);
        check("rst_bsel", 32'(dm_bsel), 32'd0);
        check("rst_dmaddr", 32'(dm_addr), 32'd0);
        check("rst_dmdin", dm_din, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "st_w", got);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_w", got);
        check("tp_ld_w", got, 32'hDEADBEEF);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "ld_b13s", got);
        check("tp_b13s", got, 32'hFFFFFFDE);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "ld_b13u", got);
        check("tp_b13u", got, 32'h000000DE);
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, "ld_b10s", got);
        check("tp_b10s", got, 32'hFFFFFFEF);
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, "st_h", got);
        do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "ld_hs", got);
        check("tp_hs", got, 32'hFFFF8001);
        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "ld_hu", got);
        check("tp_hu", got, 32'h00008001);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "ld_w20", got);
        check("tp_w20_hi", {16'h0, got[31:16]}, 32'h8001);

        do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, "err_wmis", got);
        do_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, "err_hmis", got);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, "err_size", got);
        do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, "err_range", got);
        do_req(1'b1, 2'd2, 1'b0, 32'h1010, 32'h12345678, "err_strng", got);
        do_req(1'b1, 2'd3, 1'b0, 32'h14, 32'hCAFEF00D, "err_stsz", got);

        // Back-to-back word loads with req_valid held high
        bb_addr[0] = 32'h10; bb_addr[1] = 32'h20; bb_addr[2] = 32'h40;
        for (int i = 0; i < 3; i++)
            ref_exec(1'b0, 2'd2, 1'b0, bb_addr[i], 32'h0, bb_exp[i], e_err, e_lat, e_nwe);
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = bb_addr[0];
        req_valid = 1'b1;
        hs = 0; rs = 0;
        for (int c = 0; c < 40 && rs < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid) begin
                check($sformatf("bb_rdata%0d", rs), resp_rdata, bb_exp[rs]);
                rs++;
            end
            if (hs > 0 && hs < 3) req_addr = bb_addr[hs];
            if (hs == 3) req_valid = 1'b0;
            if (req_ready && hs < 3) begin
                hs_cyc[hs] = c;
                hs++;
            end
        end
        req_valid = 1'b0;
        check("bb_resp_cnt", rs, 3);
        check("bb_gap1", hs_cyc[1] - hs_cyc[0], 3);
        check("bb_gap2", hs_cyc[2] - hs_cyc[1], 3);

        // Async reset during ACC1 of a half store: only the low byte lands
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h42; req_wdata = 32'h00005AA5;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("ar_pre_we", 32'(dm_we), 32'd1);
        check("ar_pre_bsel", 32'(dm_bsel), 32'd3);
        rst_n = 1'b0;
        #1;
        check("ar_dmwe", 32'(dm_we), 32'd0);
        check("ar_rvalid", 32'(resp_valid), 32'd0);
        check("ar_ready", 32'(req_ready), 32'd1);
        ref_mem[32'h42] = 8'hA5;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) s++;
        end
        check("ar_noresp", s, 0);
        check("ar_ready_rel", 32'(req_ready), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "ar_ldw", got);

        for (int t = 0; t < 300; t++) begin
            s = $urandom_range(0, 9);
            size = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
            s = $urandom_range(0, 15);
            if (s == 0)      a = $urandom | 32'h1000;
            else if (s == 1) a = $urandom_range(0, 4095);
            else             a = 32'h100 + $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) a[0] = 1'b0;
                if (size == 2'd2) a[1:0] = 2'b00;
            end
            wd = $urandom;
            do_req(1'($urandom), size, 1'($urandom), a, wd, $sformatf("rnd%0d", t), got);
        end

        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (dm_mem[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]})
                mism++;
        check("mem_final", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
